// File: rtl/vga_timing_monitor.sv
// Receive-side VGA checker: measures hsync/vsync timing, locks onto an H_TOTAL x V_TOTAL
// raster, regenerates visible-pixel coordinates and a per-frame R+G+B checksum.
module vga_timing_monitor #(
   parameter int H_TOTAL     = 800,
   parameter int V_TOTAL     = 525,
   parameter int LOCK_FRAMES = 2,
   parameter bit SYNC_POL    = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        hsync,
   input  logic        vsync,
   input  logic        blank,
   input  logic [7:0]  R,
   input  logic [7:0]  G,
   input  logic [7:0]  B,
   output logic        locked,
   output logic        err,
   output logic        frame_done,
   output logic [9:0]  line_len,
   output logic [9:0]  frame_lines,
   output logic [9:0]  pix_x,
   output logic [9:0]  pix_y,
   output logic        pix_valid,
   output logic [15:0] frame_sum,
   output logic [1:0]  fsm_state
);

   localparam logic [1:0] SEARCH  = 2'd0;
   localparam logic [1:0] MEASURE = 2'd1;
   localparam logic [1:0] LOCKED  = 2'd2;

   localparam logic [9:0] H_TOT    = 10'(H_TOTAL);
   localparam logic [9:0] V_TOT    = 10'(V_TOTAL);
   localparam logic [3:0] LOCK_N   = 4'(LOCK_FRAMES);
   localparam logic [9:0] HCNT_MAX = 10'd1023;

   logic        hs_q, vs_q, blank_q;
   logic [9:0]  hcnt, vcnt, xc, yc;
   logic        h_seen, bad_f, line_vis;
   logic [1:0]  state, state_n;
   logic [3:0]  good_cnt, good_n;
   logic        err_n, done_n;
   logic [15:0] acc;

   logic        h_lead, v_lead, bad_line, good_frame, sig_lost;
   logic [9:0]  lines_now, pix_sum, vis_add, x_now, y_now;

   // A leading edge is the raw input at the active level while its registered copy is not.
   assign h_lead     = (hs_q != SYNC_POL) && (hsync == SYNC_POL);
   assign v_lead     = (vs_q != SYNC_POL) && (vsync == SYNC_POL);
   assign bad_line   = h_lead && h_seen && (hcnt != H_TOT);
   assign lines_now  = vcnt + {9'd0, h_lead};
   assign good_frame = (lines_now == V_TOT) && !bad_f && !bad_line;
   assign sig_lost   = (state != SEARCH) && (hcnt == HCNT_MAX);
   assign pix_sum    = {2'b00, R} + {2'b00, G} + {2'b00, B};
   assign vis_add    = blank ? pix_sum : 10'd0;

   // pix_valid qualifies pix_x/pix_y; both carry the pixel sampled one cycle earlier.
   assign locked    = (state == LOCKED);
   assign pix_valid = locked & blank_q;
   assign fsm_state = state;

   always_comb begin
      x_now = h_lead ? 10'd0 : xc;
      y_now = yc;
      if (h_lead && line_vis) y_now = yc + 10'd1;
      if (v_lead) y_now = 10'd0;
   end

   always_comb begin
      state_n = state;
      good_n  = good_cnt;
      err_n   = 1'b0;
      done_n  = 1'b0;
      if (sig_lost) begin
         state_n = SEARCH;
         err_n   = 1'b1;
      end else begin
         case (state)
            SEARCH: begin
               if (v_lead) begin
                  state_n = MEASURE;
                  good_n  = 4'd0;
               end
            end
            MEASURE: begin
               if (v_lead) begin
                  if (good_frame) begin
                     good_n = good_cnt + 4'd1;
                     if (good_n == LOCK_N) state_n = LOCKED;
                  end else begin
                     good_n = 4'd0;
                     err_n  = 1'b1;
                  end
               end
            end
            LOCKED: begin
               if (bad_line || (v_lead && !good_frame)) begin
                  state_n = MEASURE;
                  good_n  = 4'd0;
                  err_n   = 1'b1;
               end else if (v_lead) begin
                  done_n = 1'b1;
               end
            end
            default: state_n = SEARCH;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hs_q        <= SYNC_POL;
         vs_q        <= SYNC_POL;
         blank_q     <= 1'b0;
         hcnt        <= 10'd0;
         vcnt        <= 10'd0;
         xc          <= 10'd0;
         yc          <= 10'd0;
         h_seen      <= 1'b0;
         bad_f       <= 1'b0;
         line_vis    <= 1'b0;
         state       <= SEARCH;
         good_cnt    <= 4'd0;
         err         <= 1'b0;
         frame_done  <= 1'b0;
         line_len    <= 10'd0;
         frame_lines <= 10'd0;
         pix_x       <= 10'd0;
         pix_y       <= 10'd0;
         acc         <= 16'd0;
         frame_sum   <= 16'd0;
      end else begin
         hs_q    <= hsync;
         vs_q    <= vsync;
         blank_q <= blank;

         if (h_lead) begin
            line_len <= hcnt;
            hcnt     <= 10'd1;
         end else if (hcnt != HCNT_MAX) begin
            hcnt <= hcnt + 10'd1;
         end

         if (sig_lost)    h_seen <= 1'b0;
         else if (h_lead) h_seen <= 1'b1;

         // Line is processed before frame, so a bad line in the v_lead cycle is consumed here.
         if (v_lead)        bad_f <= 1'b0;
         else if (bad_line) bad_f <= 1'b1;

         if (v_lead) begin
            vcnt        <= 10'd0;
            frame_lines <= lines_now;
         end else if (h_lead) begin
            vcnt <= vcnt + 10'd1;
         end

         if (h_lead)     line_vis <= blank;
         else if (blank) line_vis <= 1'b1;

         xc    <= x_now + {9'd0, blank};
         yc    <= y_now;
         pix_x <= x_now;
         pix_y <= y_now;

         if (v_lead) begin
            frame_sum <= acc + {6'd0, vis_add};
            acc       <= 16'd0;
         end else begin
            acc <= acc + {6'd0, vis_add};
         end

         state      <= state_n;
         good_cnt   <= good_n;
         err        <= err_n;
         frame_done <= done_n;
      end
   end

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor on a reduced 64 x 30 raster (40 x 24 visible);
// frame-end and error events are matched against an expected-event queue.
module tb_vga_timing_monitor;

   localparam int H        = 64;
   localparam int V        = 30;
   localparam int VIS_W    = 40;
   localparam int VIS_H    = 24;
   localparam int ONES_SUM = 2880;   // 40*24 pixels * (1+1+1)

   localparam logic [1:0] K_NONE = 2'b00;
   localparam logic [1:0] K_DONE = 2'b01;
   localparam logic [1:0] K_ERR  = 2'b10;

   localparam logic [1:0] ST_SEARCH  = 2'd0;
   localparam logic [1:0] ST_MEASURE = 2'd1;

   logic        clk = 1'b0;
   logic        reset;
   logic        hsync, vsync, blank;
   logic [7:0]  R, G, B;
   logic        locked, err, frame_done, pix_valid;
   logic [9:0]  line_len, frame_lines, pix_x, pix_y;
   logic [15:0] frame_sum;
   logic [1:0]  fsm_state;

   // {kind[1:0], frame_sum[15:0], frame_lines[9:0]}
   logic [27:0] exp_q[$];
   logic [27:0] mon_e;
   logic [15:0] prev_sum;
   logic [9:0]  prev_lines;

   int checks = 0;
   int errors = 0;

   logic track = 1'b0;
   int   pix_cnt = 0;
   int   max_x = 0;
   int   max_y = 0;
   int   first_x = -1;
   int   first_y = -1;

   vga_timing_monitor #(
      .H_TOTAL(H), .V_TOTAL(V), .LOCK_FRAMES(2), .SYNC_POL(1'b0)
   ) dut (
      .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .blank(blank),
      .R(R), .G(G), .B(B),
      .locked(locked), .err(err), .frame_done(frame_done),
      .line_len(line_len), .frame_lines(frame_lines),
      .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
      .frame_sum(frame_sum), .fsm_state(fsm_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] out_vec();
      return {2'b00, locked, err, frame_done, pix_valid, line_len, frame_lines,
              pix_x, pix_y, frame_sum, fsm_state};
   endfunction

   // driver tasks
   task automatic hold_idle(input int n);
      for (int i = 0; i < n; i++) begin
         hsync = 1'b1; vsync = 1'b1; blank = 1'b0;
         R = 8'd0; G = 8'd0; B = 8'd0;
         @(posedge clk); #1;
      end
   endtask

   task automatic drive_frame(input logic [1:0] prev_kind, input int mode,
                              input int short_line, input int rst_line);
      int  sum, lines, len, r, g, b;
      bit  vis;
      if (prev_kind != K_NONE) exp_q.push_back({prev_kind, prev_sum, prev_lines});
      sum = 0;
      lines = 0;
      for (int y = 0; y < V; y++) begin
         len = (y == short_line) ? H - 1 : H;
         if (y == short_line) exp_q.push_back({K_ERR, 16'd0, 10'd0});
         lines++;
         for (int x = 0; x < len; x++) begin
            if (y == rst_line && x == 1) begin
               chk("reset_midframe_outputs", out_vec(), 64'd0);
            end
            if (short_line >= 0 && y == short_line + 1 && x == 2) begin
               chk("short_line_len", line_len, H - 1);
               chk("short_line_unlock", locked, 0);
               chk("short_line_state", fsm_state, ST_MEASURE);
            end
            reset = (y == rst_line && x == 0);
            vis   = (x >= 16) && (x < 16 + VIS_W) && (y >= 4) && (y < 4 + VIS_H);
            hsync = (x < 8) ? 1'b0 : 1'b1;
            vsync = (y < 2) ? 1'b0 : 1'b1;
            blank = vis;
            if (mode == 0) begin
               r = 1; g = 1; b = 1;
            end else begin
               r = (x * 3) & 255; g = (y * 7) & 255; b = (x ^ 165) & 255;
            end
            if (!vis) begin
               r = 0; g = 0; b = 0;
            end
            R = 8'(r); G = 8'(g); B = 8'(b);
            sum += r + g + b;
            @(posedge clk); #1;
         end
      end
      reset = 1'b0;
      prev_sum   = 16'(sum);
      prev_lines = 10'(lines);
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (err || frame_done) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event actual=err%b/done%b required=none", err, frame_done);
         end else begin
            mon_e = exp_q.pop_front();
            chk("event_kind", {err, frame_done}, mon_e[27:26]);
            if (mon_e[27:26] == K_DONE) begin
               chk("frame_sum", frame_sum, mon_e[25:10]);
               chk("frame_lines", frame_lines, mon_e[9:0]);
               chk("line_len", line_len, H);
            end
         end
      end
      if (track && pix_valid) begin
         if (pix_cnt == 0) begin
            first_x = int'(pix_x);
            first_y = int'(pix_y);
         end
         pix_cnt++;
         if (int'(pix_x) > max_x) max_x = int'(pix_x);
         if (int'(pix_y) > max_y) max_y = int'(pix_y);
      end
   end

   initial begin
      reset = 1'b1;
      hsync = 1'b1; vsync = 1'b1; blank = 1'b0;
      R = 8'd0; G = 8'd0; B = 8'd0;
      prev_sum = 16'd0;
      prev_lines = 10'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", out_vec(), 64'd0);
      reset = 1'b0;

      // idle after reset
      hold_idle(100);
      chk("idle_outputs", out_vec(), 64'd0);

      // nominal raster: lock on the third v_lead
      drive_frame(K_NONE, 1, -1, -1);
      drive_frame(K_NONE, 1, -1, -1);
      chk("unlocked_after_2_vleads", locked, 0);
      drive_frame(K_NONE, 1, -1, -1);
      chk("locked_after_3_vleads", locked, 1);
      chk("nominal_line_len", line_len, H);
      chk("nominal_frame_lines", frame_lines, V);
      drive_frame(K_DONE, 1, -1, -1);

      // all-ones pixels, coordinate coverage
      track = 1'b1;
      drive_frame(K_DONE, 0, -1, -1);
      track = 1'b0;
      chk("pix_count", pix_cnt, VIS_W * VIS_H);
      chk("pix_x_max", max_x, VIS_W - 1);
      chk("pix_y_max", max_y, VIS_H - 1);
      chk("pix_first_xy", {first_x, first_y}, 64'd0);
      drive_frame(K_DONE, 0, -1, -1);

      // one short line while locked
      drive_frame(K_DONE, 1, 10, -1);
      chk("ones_frame_sum", frame_sum, ONES_SUM);
      drive_frame(K_ERR, 1, -1, -1);
      drive_frame(K_NONE, 1, -1, -1);
      chk("relock_wait", locked, 0);
      drive_frame(K_NONE, 1, -1, -1);
      chk("relocked", locked, 1);
      drive_frame(K_DONE, 1, -1, -1);

      // signal loss while locked
      exp_q.push_back({K_ERR, 16'd0, 10'd0});
      hold_idle(1100);
      chk("loss_state", fsm_state, ST_SEARCH);
      chk("loss_unlock", locked, 0);
      drive_frame(K_NONE, 1, -1, -1);
      chk("resume_state", fsm_state, ST_MEASURE);
      drive_frame(K_NONE, 1, -1, -1);
      drive_frame(K_NONE, 1, -1, -1);
      chk("loss_relocked", locked, 1);

      // reset mid-frame, then relock after three v_leads
      drive_frame(K_DONE, 1, -1, 15);
      drive_frame(K_NONE, 1, -1, -1);
      chk("post_reset_state", fsm_state, ST_MEASURE);
      drive_frame(K_NONE, 1, -1, -1);
      chk("post_reset_unlocked", locked, 0);
      drive_frame(K_NONE, 1, -1, -1);
      chk("post_reset_relocked", locked, 1);
      drive_frame(K_DONE, 1, -1, -1);
      hold_idle(20);

      chk("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
